obi_mem_arbiter: RTL and testbench

Two-host OBI arbiter for the DV memory model. It shares one OBI device port (the random-wait memory model) between host 0 (instruction fetch) and host 1 (data load/store). It selects a host, holds that selection stable until the device grants, and records each granted owner in an in-order tracking FIFO. Responses are routed back to the owning host in issue order. It sits in the testbench between the core's instr/data OBI ports and a single memory model instance.

---
 rtl/cheriot_dv_pkg.sv | 20 ++
 rtl/obi_owner_fifo.sv | 54 +++++
 rtl/obi_mem_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheriot_dv_pkg.sv
// Shared types for the DV OBI arbiter: host IDs, selection FSM states.
package cheriot_dv_pkg;

  // One-bit host identifier stored in the response-tracking FIFO.
  typedef logic obi_owner_t;

  // Selection FSM: IDLE picks a winner combinationally, HOLD pins the owner.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam obi_owner_t HOST_INSTR = 1'b0;
  localparam obi_owner_t HOST_DATA  = 1'b1;

  function automatic obi_owner_t other_host(input obi_owner_t h);
    return ~h;
  endfunction

endpackage

// File: rtl/obi_owner_fifo.sv
// In-order FIFO of granted-transaction owners. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module obi_owner_fifo
  import cheriot_dv_pkg::*;
#(
  parameter  int unsigned NOUT = 8,
  localparam int unsigned PW   = $clog2(NOUT) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_push,
  input  obi_owner_t    i_push_id,
  input  logic          i_pop,
  output obi_owner_t    o_head,
  output logic [PW-1:0] o_occupancy,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned IW = PW - 1;

  obi_owner_t    r_mem [NOUT];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic          w_push;
  logic          w_pop;

  assign o_occupancy = r_wr - r_rd;
  assign o_full      = (o_occupancy == PW'(NOUT));
  assign o_empty     = (o_occupancy == '0);
  assign o_head      = r_mem[r_rd[IW-1:0]];
  assign w_push      = i_push & ~o_full;
  assign w_pop       = i_pop & ~o_empty;

  // Pointer and storage update; a simultaneous pop reads the old head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int unsigned i = 0; i < NOUT; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr[IW-1:0]] <= i_push_id;
        r_wr                <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-host OBI arbiter in front of the DV memory model. Host 0 is
// instruction fetch, host 1 is data. A selected request is held stable
// until the device grants; responses are routed in issue order.
// Build option CHERIOT_OBI_ARB_RR_EN: round-robin tie-break instead of
// fixed host-0 priority.
module obi_mem_arbiter
  import cheriot_dv_pkg::*;
#(
  parameter  int unsigned DW   = 32,
  parameter  int unsigned NOUT = 8,
  localparam int unsigned OW   = $clog2(NOUT) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // host 0 (instruction fetch)
  input  logic          h0_req,
  input  logic          h0_we,
  input  logic [3:0]    h0_be,
  input  logic          h0_is_cap,
  input  logic [31:0]   h0_addr,
  input  logic [DW-1:0] h0_wdata,
  input  logic [7:0]    h0_flag,
  output logic          h0_gnt,
  output logic          h0_rvalid,
  output logic [DW-1:0] h0_rdata,
  output logic          h0_err,
  // host 1 (data)
  input  logic          h1_req,
  input  logic          h1_we,
  input  logic [3:0]    h1_be,
  input  logic          h1_is_cap,
  input  logic [31:0]   h1_addr,
  input  logic [DW-1:0] h1_wdata,
  input  logic [7:0]    h1_flag,
  output logic          h1_gnt,
  output logic          h1_rvalid,
  output logic [DW-1:0] h1_rdata,
  output logic          h1_err,
  // device
  output logic          dev_req,
  output logic          dev_we,
  output logic [3:0]    dev_be,
  output logic          dev_is_cap,
  output logic [31:0]   dev_addr,
  output logic [DW-1:0] dev_wdata,
  output logic [7:0]    dev_flag,
  input  logic          dev_gnt,
  input  logic          dev_rvalid,
  input  logic [DW-1:0] dev_rdata,
  input  logic          dev_err,
  // status
  output logic [OW-1:0] outstanding,
  output logic          protocol_err
);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  obi_owner_t    r_owner;
  obi_owner_t    w_owner_nxt;
  obi_owner_t    w_winner;
  obi_owner_t    w_sel;
  obi_owner_t    w_head;
  logic          w_owner_req;
  logic          w_dev_req;
  logic          w_hold_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_orphan;
  logic          w_full;
  logic          w_empty;
  logic [OW-1:0] w_occ;

`ifdef CHERIOT_OBI_ARB_RR_EN
  obi_owner_t r_prio;

  // Tie goes to the host that did not win the previous grant.
  always_comb begin
    w_winner = HOST_INSTR;
    if (h0_req && h1_req) begin
      w_winner = r_prio;
    end else if (h1_req) begin
      w_winner = HOST_DATA;
    end
  end

  // Priority pointer flips away from whoever was just granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio <= HOST_INSTR;
    end else if (w_push) begin
      r_prio <= other_host(w_sel);
    end
  end
`else
  // Fixed priority: host 0 wins whenever it requests.
  always_comb begin
    w_winner = HOST_INSTR;
    if (h1_req && !h0_req) begin
      w_winner = HOST_DATA;
    end
  end
`endif

  assign w_owner_req = (r_owner == HOST_DATA) ? h1_req : h0_req;

  // FSM state and held owner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
      r_owner <= HOST_INSTR;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Next state: enter HOLD on an ungranted request, leave on grant or abandon.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_dev_req && !dev_gnt) begin
          w_state_nxt = ARB_HOLD;
          w_owner_nxt = w_winner;
        end
      end
      ARB_HOLD: begin
        if (!w_owner_req || dev_gnt) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Selection, device request and command mux; fields are zero when idle.
  always_comb begin
    w_sel       = r_owner;
    w_dev_req   = 1'b0;
    w_hold_drop = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        w_sel     = w_winner;
        w_dev_req = ~w_full & (h0_req | h1_req);
      end
      ARB_HOLD: begin
        w_sel       = r_owner;
        w_dev_req   = w_owner_req;
        w_hold_drop = ~w_owner_req;
      end
      default: ;
    endcase

    dev_we     = 1'b0;
    dev_be     = '0;
    dev_is_cap = 1'b0;
    dev_addr   = '0;
    dev_wdata  = '0;
    dev_flag   = '0;
    if (w_dev_req) begin
      if (w_sel == HOST_DATA) begin
        dev_we     = h1_we;
        dev_be     = h1_be;
        dev_is_cap = h1_is_cap;
        dev_addr   = h1_addr;
        dev_wdata  = h1_wdata;
        dev_flag   = h1_flag;
      end else begin
        dev_we     = h0_we;
        dev_be     = h0_be;
        dev_is_cap = h0_is_cap;
        dev_addr   = h0_addr;
        dev_wdata  = h0_wdata;
        dev_flag   = h0_flag;
      end
    end
  end

  assign dev_req  = w_dev_req;
  assign w_push   = dev_gnt & w_dev_req;
  assign h0_gnt   = w_push & (w_sel == HOST_INSTR);
  assign h1_gnt   = w_push & (w_sel == HOST_DATA);

  assign w_pop    = dev_rvalid & ~w_empty;
  assign w_orphan = dev_rvalid & w_empty;

  assign h0_rvalid = w_pop & (w_head == HOST_INSTR);
  assign h1_rvalid = w_pop & (w_head == HOST_DATA);
  assign h0_rdata  = h0_rvalid ? dev_rdata : '0;
  assign h1_rdata  = h1_rvalid ? dev_rdata : '0;
  assign h0_err    = h0_rvalid & dev_err;
  assign h1_err    = h1_rvalid & dev_err;

  assign outstanding = w_occ;

  // Sticky flag: response with nothing outstanding, or owner abandoned HOLD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      protocol_err <= 1'b0;
    end else if (w_orphan || w_hold_drop) begin
      protocol_err <= 1'b1;
    end
  end

  obi_owner_fifo #(
    .NOUT(NOUT)
  ) u_owner_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_push     (w_push),
    .i_push_id  (w_sel),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_occupancy(w_occ),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Scoreboard bench for obi_mem_arbiter: host and device BFMs, expected
// grant/response queues filled by the stimulus, a negedge monitor checks.
// Tie-break expectations follow CHERIOT_OBI_ARB_RR_EN when defined.
module tb_obi_mem_arbiter;

  localparam int unsigned DW   = 32;
  localparam int unsigned NOUT = 8;
  localparam int unsigned OW   = $clog2(NOUT) + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          h0_req = 1'b0, h1_req = 1'b0;
  logic          h0_we = 1'b0, h1_we = 1'b0;
  logic [3:0]    h0_be = 4'hF, h1_be = 4'hF;
  logic          h0_is_cap = 1'b0, h1_is_cap = 1'b0;
  logic [31:0]   h0_addr = '0, h1_addr = '0;
  logic [DW-1:0] h0_wdata = '0, h1_wdata = '0;
  logic [7:0]    h0_flag = 8'hA0, h1_flag = 8'hB1;
  logic          h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, h0_err, h1_err;
  logic [DW-1:0] h0_rdata, h1_rdata;
  logic          dev_req, dev_we, dev_is_cap;
  logic [3:0]    dev_be;
  logic [31:0]   dev_addr;
  logic [DW-1:0] dev_wdata;
  logic [7:0]    dev_flag;
  logic          dev_gnt = 1'b0, dev_rvalid = 1'b0, dev_err = 1'b0;
  logic [DW-1:0] dev_rdata = '0;
  logic [OW-1:0] outstanding;
  logic          protocol_err;

  obi_mem_arbiter #(.DW(DW), .NOUT(NOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .h0_req(h0_req), .h0_we(h0_we), .h0_be(h0_be), .h0_is_cap(h0_is_cap),
    .h0_addr(h0_addr), .h0_wdata(h0_wdata), .h0_flag(h0_flag),
    .h0_gnt(h0_gnt), .h0_rvalid(h0_rvalid), .h0_rdata(h0_rdata), .h0_err(h0_err),
    .h1_req(h1_req), .h1_we(h1_we), .h1_be(h1_be), .h1_is_cap(h1_is_cap),
    .h1_addr(h1_addr), .h1_wdata(h1_wdata), .h1_flag(h1_flag),
    .h1_gnt(h1_gnt), .h1_rvalid(h1_rvalid), .h1_rdata(h1_rdata), .h1_err(h1_err),
    .dev_req(dev_req), .dev_we(dev_we), .dev_be(dev_be), .dev_is_cap(dev_is_cap),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_flag(dev_flag),
    .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata), .dev_err(dev_err),
    .outstanding(outstanding), .protocol_err(protocol_err)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          host;
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  rsp_t        exp_rsp[$];
  logic        exp_gnt[$];
  logic [31:0] hq0[$];
  logic [31:0] hq1[$];
  rsp_t        devq[$];
  logic        en0 = 1'b0, en1 = 1'b0;
  logic        rsp_en = 1'b0, inj = 1'b0, drv_q = 1'b0;
  int unsigned gnt_wait = 0;
  int unsigned gcnt = 0;

  // Memory contents: data is address XOR a constant, 0xE... addresses fault.
  function automatic rsp_t mem_rsp(input logic host, input logic [31:0] a);
    rsp_t r;
    r.host = host;
    r.err  = (a[31:28] == 4'hE);
    r.data = a ^ 32'hC0DE_0000;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic host, input logic [31:0] a);
    if (host) hq1.push_back(a);
    else      hq0.push_back(a);
    exp_gnt.push_back(host);
    exp_rsp.push_back(mem_rsp(host, a));
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic drain(input string name);
    int unsigned k = 0;
    while ((exp_rsp.size() != 0 || exp_gnt.size() != 0) && k < 300) begin
      @(negedge clk_i);
      k++;
    end
    check(name, 64'(exp_rsp.size() + exp_gnt.size()), 64'h0);
    en0 = 1'b0;
    en1 = 1'b0;
    cycles(2);
  endtask

  // Host BFMs: present queue head, advance on grant.
  always @(posedge clk_i) begin
    if (h0_gnt && hq0.size() != 0) void'(hq0.pop_front());
    if (h1_gnt && hq1.size() != 0) void'(hq1.pop_front());
    #1;
    h0_req  = en0 && hq0.size() != 0;
    h0_addr = (hq0.size() != 0) ? hq0[0] : '0;
    h1_req  = en1 && hq1.size() != 0;
    h1_addr = (hq1.size() != 0) ? hq1[0] : '0;
  end

  // Device BFM: grant after gnt_wait request cycles, in-order responses.
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      devq.delete();
      gcnt = 0;
    end else begin
      if (dev_rvalid && drv_q) void'(devq.pop_front());
      if (dev_req && dev_gnt) devq.push_back(mem_rsp(1'b0, dev_addr));
      if (!dev_req || dev_gnt) gcnt = 0;
      else gcnt++;
    end
    #1;
    dev_gnt    = (gcnt >= gnt_wait);
    drv_q      = !inj && rsp_en && devq.size() != 0;
    dev_rvalid = inj || drv_q;
    dev_rdata  = inj ? 32'hDEAD_BEEF : (drv_q ? devq[0].data : '0);
    dev_err    = drv_q ? devq[0].err : 1'b0;
  end

  // Monitor: compare every grant and response against the expected queues.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (h0_gnt || h1_gnt) begin
        if (exp_gnt.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL gnt_unexpected: got h0_gnt=%0b h1_gnt=%0b, expected none", h0_gnt, h1_gnt);
        end else begin
          logic e;
          e = exp_gnt.pop_front();
          check("gnt_owner", 64'({h0_gnt, h1_gnt}), 64'({~e, e}));
        end
      end
      if (h0_rvalid || h1_rvalid) begin
        if (exp_rsp.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got h0_rvalid=%0b h1_rvalid=%0b, expected none", h0_rvalid, h1_rvalid);
        end else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          check("rsp_route", 64'({h0_rvalid, h1_rvalid}), 64'({~e.host, e.host}));
          check("rsp_data", 64'(e.host ? h1_rdata : h0_rdata), 64'(e.data));
          check("rsp_err", 64'(e.host ? h1_err : h0_err), 64'(e.err));
          check("rsp_other_rdata", 64'(e.host ? h0_rdata : h1_rdata), 64'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    cycles(2);
    check("rst_outstanding", 64'(outstanding), 64'h0);
    check("rst_protocol_err", 64'(protocol_err), 64'h0);
    check("rst_dev_req", 64'(dev_req), 64'h0);
    check("rst_dev_addr", 64'(dev_addr), 64'h0);
    check("rst_dev_flag", 64'(dev_flag), 64'h0);
    check("rst_gnt", 64'({h0_gnt, h1_gnt}), 64'h0);
    check("rst_rvalid", 64'({h0_rvalid, h1_rvalid}), 64'h0);
    check("rst_rdata", 64'(h0_rdata | h1_rdata), 64'h0);
    rst_ni = 1'b1;
    cycles(2);

    // Zero-wait single-host flow on host 1.
    gnt_wait = 0;
    rsp_en   = 1'b1;
    for (int i = 0; i < 4; i++) issue(1'b1, 32'h100 + 32'(4 * i));
    en1 = 1'b1;
    drain("t1_drain");
    check("t1_outstanding", 64'(outstanding), 64'h0);

    // Tie resolution with both hosts requesting continuously.
`ifdef CHERIOT_OBI_ARB_RR_EN
    for (int i = 0; i < 10; i++) begin
      issue(1'b0, 32'h2000 + 32'(4 * i));
      issue(1'b1, (i == 2) ? 32'hE000_3008 : 32'h3000 + 32'(4 * i));
    end
`else
    for (int i = 0; i < 20; i++) issue(1'b0, 32'h2000 + 32'(4 * i));
    issue(1'b1, 32'h3000);
    issue(1'b1, 32'hE000_3004);
`endif
    en0 = 1'b1;
    en1 = 1'b1;
    drain("t2_drain");

    // Hold stability: host 1 waits for a slow grant while host 0 arrives.
    gnt_wait = 7;
    issue(1'b1, 32'h400);
    issue(1'b0, 32'h500);
    en1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (i == 2) en0 = 1'b1;
      if (dev_req) begin
        check("t3_hold_addr", 64'(dev_addr), 64'h400);
        check("t3_hold_flag", 64'(dev_flag), 64'hB1);
      end
      if (h1_gnt) break;
    end
    drain("t3_drain");
    gnt_wait = 0;

    // Full FIFO with responses back-pressured.
    rsp_en = 1'b0;
    for (int i = 0; i < 10; i++) issue(1'b0, 32'h600 + 32'(4 * i));
    en0 = 1'b1;
    cycles(12);
    check("t4_full_outstanding", 64'(outstanding), 64'h8);
    check("t4_full_dev_req", 64'(dev_req), 64'h0);
    check("t4_full_h0_gnt", 64'(h0_gnt), 64'h0);
    rsp_en = 1'b1;
    @(negedge clk_i);
    check("t4_rv_h0_rvalid", 64'(h0_rvalid), 64'h1);
    check("t4_rv_dev_req", 64'(dev_req), 64'h0);
    check("t4_rv_outstanding", 64'(outstanding), 64'h8);
    @(negedge clk_i);
    check("t4_resume_dev_req", 64'(dev_req), 64'h1);
    check("t4_resume_outstanding", 64'(outstanding), 64'h7);
    drain("t4_drain");

    // Simultaneous push and pop at occupancy 3.
    rsp_en = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b1, 32'h700 + 32'(4 * i));
    en1 = 1'b1;
    cycles(6);
    check("t5_pre_outstanding", 64'(outstanding), 64'h3);
    issue(1'b0, 32'h800);
    en0    = 1'b1;
    rsp_en = 1'b1;
    @(negedge clk_i);
    check("t5_both_h0_gnt", 64'(h0_gnt), 64'h1);
    check("t5_both_h1_rvalid", 64'(h1_rvalid), 64'h1);
    @(negedge clk_i);
    check("t5_post_outstanding", 64'(outstanding), 64'h3);
    drain("t5_drain");

    // Protocol error: response with nothing outstanding.
    check("t6a_pre_perr", 64'(protocol_err), 64'h0);
    inj = 1'b1;
    @(negedge clk_i);
    check("t6a_no_rvalid", 64'({h0_rvalid, h1_rvalid}), 64'h0);
    inj = 1'b0;
    @(negedge clk_i);
    check("t6a_perr", 64'(protocol_err), 64'h1);
    check("t6a_outstanding", 64'(outstanding), 64'h0);
    cycles(3);
    check("t6a_perr_sticky", 64'(protocol_err), 64'h1);

    // Protocol error: owner drops request during HOLD.
    rst_ni = 1'b0;
    cycles(2);
    check("t6b_rst_perr", 64'(protocol_err), 64'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    gnt_wait = 7;
    hq0.push_back(32'h900);
    en0 = 1'b1;
    cycles(3);
    check("t6b_hold_dev_req", 64'(dev_req), 64'h1);
    check("t6b_hold_perr", 64'(protocol_err), 64'h0);
    en0 = 1'b0;
    @(negedge clk_i);
    check("t6b_drop_dev_req", 64'(dev_req), 64'h0);
    check("t6b_drop_h0_gnt", 64'(h0_gnt), 64'h0);
    @(negedge clk_i);
    check("t6b_perr", 64'(protocol_err), 64'h1);
    check("t6b_outstanding", 64'(outstanding), 64'h0);
    cycles(3);
    check("t6b_perr_sticky", 64'(protocol_err), 64'h1);
    hq0.delete();
    gnt_wait = 0;

    cycles(2);
    check("final_queues", 64'(exp_rsp.size() + exp_gnt.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
